// File: rtl/uart_sched_pkg.sv
// Shared types and helpers for the UART transmit scheduler.
package uart_sched_pkg;

    localparam int DEF_NUM_REQ       = 4;
    localparam int DEF_START_TIMEOUT = 64;
    localparam int DEF_CNT_W         = 16;
    localparam int MAX_REQ           = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_START,
        S_WAIT_BUSY,
        S_WAIT_DONE
    } sched_state_t;

    // Round-robin pick: first set bit of req strictly after ptr, wrapping
    // within n requesters. Scanning from the farthest offset down lets the
    // nearest candidate overwrite the result last.
    function automatic logic [2:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                           input logic [2:0]         ptr,
                                           input int                 n);
        logic [2:0] win;
        int         idx;
        win = '0;
        for (int k = MAX_REQ; k >= 1; k--) begin
            if (k <= n) begin
                idx = int'(ptr) + k;
                if (idx >= n) begin
                    idx = idx - n;
                end
                if (req[idx]) begin
                    win = 3'(idx);
                end
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/uart_tx_sched_rr_arbiter.sv
// Combinational round-robin picker; shared with the RX dispatch path.
module rr_arbiter
    import uart_sched_pkg::*;
#(
    parameter int N     = DEF_NUM_REQ,
    parameter int IDX_W = $clog2(N)
)(
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] winner,
    output logic             any_valid
);

    logic [MAX_REQ-1:0] req_pad;
    logic [2:0]         win_full;

    // Zero-extend the request vector to the helper's fixed width.
    for (genvar gi = 0; gi < MAX_REQ; gi++) begin : g_pad
        if (gi < N) begin : g_live
            assign req_pad[gi] = req[gi];
        end else begin : g_zero
            assign req_pad[gi] = 1'b0;
        end
    end

    assign win_full  = rr_pick(req_pad, 3'(ptr), N);
    assign winner    = IDX_W'(win_full);
    assign any_valid = |req;

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one UART transmitter among NUM_REQ byte producers: round-robin
// arbitration, grant lock across multi-byte messages, start strobe per byte
// and busy tracking with a start timeout.
module uart_tx_sched
    import uart_sched_pkg::*;
#(
    parameter int NUM_REQ       = DEF_NUM_REQ,
    parameter int START_TIMEOUT = DEF_START_TIMEOUT,
    parameter int CNT_W         = DEF_CNT_W,
    parameter int ID_W          = $clog2(NUM_REQ)
)(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*8-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [ID_W-1:0]      grant_id,
    output logic                 uart_tx_enable,
    output logic [7:0]           uart_tx_byte,
    output logic                 uart_tx_valid,
    input  logic                 uart_tx_busy,
    output logic                 start_err,
    input  logic                 err_clr,
    output logic [CNT_W-1:0]     bytes_sent
);

    localparam int TMR_W = $clog2(START_TIMEOUT + 1);

    sched_state_t      state_reg, state_next;
    logic [ID_W-1:0]   grant_reg, grant_next;
    logic [ID_W-1:0]   ptr_reg, ptr_next;
    logic              enable_reg, enable_next;
    logic [7:0]        byte_reg, byte_next;
    logic              last_reg, last_next;
    logic [TMR_W-1:0]  timer_reg, timer_next;
    logic              err_reg, err_next;
    logic [CNT_W-1:0]  count_reg, count_next;
    logic              set_err;
    logic [ID_W-1:0]   pick;
    logic              any_req;
    logic [7:0]        data_slice [NUM_REQ];

    // Unpack the flat data bus into one byte per requester.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
        assign data_slice[gi] = req_data[8*gi +: 8];
    end

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (ID_W)
    ) u_arb (
        .req       (req_valid),
        .ptr       (ptr_reg),
        .winner    (pick),
        .any_valid (any_req)
    );

    // State register; the pointer resets to the last index so requester 0 wins first.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= S_IDLE;
            grant_reg  <= '0;
            ptr_reg    <= ID_W'(NUM_REQ - 1);
            enable_reg <= 1'b0;
            byte_reg   <= '0;
            last_reg   <= 1'b0;
            timer_reg  <= '0;
            err_reg    <= 1'b0;
            count_reg  <= '0;
        end else begin
            state_reg  <= state_next;
            grant_reg  <= grant_next;
            ptr_reg    <= ptr_next;
            enable_reg <= enable_next;
            byte_reg   <= byte_next;
            last_reg   <= last_next;
            timer_reg  <= timer_next;
            err_reg    <= err_next;
            count_reg  <= count_next;
        end
    end

    // Next-state logic plus the one-cycle ready and start strobes.
    always_comb begin
        state_next    = state_reg;
        grant_next    = grant_reg;
        ptr_next      = ptr_reg;
        enable_next   = enable_reg;
        byte_next     = byte_reg;
        last_next     = last_reg;
        timer_next    = timer_reg;
        count_next    = count_reg;
        set_err       = 1'b0;
        req_ready     = '0;
        uart_tx_valid = 1'b0;

        case (state_reg)
            S_IDLE: begin
                // Never arbitrate while the transmitter is still busy.
                if (any_req && !uart_tx_busy) begin
                    grant_next  = pick;
                    enable_next = 1'b1;
                    state_next  = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                req_ready[grant_reg] = 1'b1;
                if (req_valid[grant_reg]) begin
                    byte_next  = data_slice[grant_reg];
                    last_next  = req_last[grant_reg];
                    state_next = S_START;
                end else begin
                    ptr_next    = grant_reg;
                    enable_next = 1'b0;
                    state_next  = S_IDLE;
                end
            end
            S_START: begin
                uart_tx_valid = 1'b1;
                count_next    = count_reg + 1'b1;
                timer_next    = '0;
                state_next    = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (uart_tx_busy) begin
                    state_next = S_WAIT_DONE;
                end else if (timer_reg == TMR_W'(START_TIMEOUT - 1)) begin
                    set_err     = 1'b1;
                    ptr_next    = grant_reg;
                    enable_next = 1'b0;
                    state_next  = S_IDLE;
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end
            S_WAIT_DONE: begin
                if (!uart_tx_busy) begin
                    if (!last_reg && req_valid[grant_reg]) begin
                        state_next = S_LAUNCH;
                    end else begin
                        ptr_next    = grant_reg;
                        enable_next = 1'b0;
                        state_next  = S_IDLE;
                    end
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        // A new timeout wins over a clear in the same cycle.
        err_next = err_clr ? 1'b0 : err_reg;
        if (set_err) begin
            err_next = 1'b1;
        end
    end

    assign grant_id       = grant_reg;
    assign uart_tx_enable = enable_reg;
    assign uart_tx_byte   = byte_reg;
    assign start_err      = err_reg;
    assign bytes_sent     = count_reg;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: directed steps plus randomized message batches,
// checked against a message-level round-robin model.
module tb_uart_tx_sched;

    localparam int N  = 4;
    localparam int TO = 20;
    localparam int CW = 16;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*8-1:0]  req_data;
    logic [N-1:0]    req_last;
    logic [N-1:0]    req_ready;
    logic [IW-1:0]   grant_id;
    logic            uart_tx_enable;
    logic [7:0]      uart_tx_byte;
    logic            uart_tx_valid;
    logic            uart_tx_busy;
    logic            start_err;
    logic            err_clr;
    logic [CW-1:0]   bytes_sent;

    always #5 clk = ~clk;

    uart_tx_sched #(
        .NUM_REQ       (N),
        .START_TIMEOUT (TO),
        .CNT_W         (CW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_data       (req_data),
        .req_last       (req_last),
        .req_ready      (req_ready),
        .grant_id       (grant_id),
        .uart_tx_enable (uart_tx_enable),
        .uart_tx_byte   (uart_tx_byte),
        .uart_tx_valid  (uart_tx_valid),
        .uart_tx_busy   (uart_tx_busy),
        .start_err      (start_err),
        .err_clr        (err_clr),
        .bytes_sent     (bytes_sent)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [8:0] pend  [N][$];   // bytes each producer still offers {last, data}
    logic [8:0] mdl_q [N][$];   // bytes the model expects to be launched
    int mdl_ptr, mdl_cur, mdl_sent;
    int busy_mode;              // 0: busy after each strobe, 1: never busy, 2: stuck busy
    int b_dly, b_len, b_on, b_off;
    logic busy_prev;
    int fall_cyc;
    int strobe_cnt;
    int seq;
    int watch_idx, watch_hits, watch_at;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic load(input int r, input logic [7:0] b, input logic l);
        pend[r].push_back({l, b});
        mdl_q[r].push_back({l, b});
    endtask

    // Present producer heads and the transmitter busy line for the current cycle.
    task automatic drive();
        logic [8:0] h;
        for (int i = 0; i < N; i++) begin
            h = (pend[i].size() > 0) ? pend[i][0] : 9'h000;
            req_valid[i]       = (pend[i].size() > 0);
            req_data[8*i +: 8] = h[7:0];
            req_last[i]        = h[8];
        end
        case (busy_mode)
            1:       uart_tx_busy = 1'b0;
            2:       uart_tx_busy = 1'b1;
            default: uart_tx_busy = (cyc >= b_on) && (cyc < b_off);
        endcase
        if (busy_prev && !uart_tx_busy) fall_cyc = cyc;
        busy_prev = uart_tx_busy;
    endtask

    // Message-level model: a new message goes to the first non-empty
    // requester after the last released one; a message keeps the grant until its last byte.
    task automatic on_strobe();
        logic [8:0] e;
        bit cont;
        int c;
        strobe_cnt++;
        seq = (seq << 4) | 32'(grant_id);
        cont = (mdl_cur >= 0);
        if (!cont) begin
            for (int k = N; k >= 1; k--) begin
                c = (mdl_ptr + k) % N;
                if (mdl_q[c].size() > 0) mdl_cur = c;
            end
        end
        checks++;
        assert (mdl_cur >= 0) else begin
            errors++;
            $error("FAIL spurious_strobe observed=strobe expected=none (cycle %0d)", cyc);
        end
        if (mdl_cur >= 0) begin
            e = mdl_q[mdl_cur].pop_front();
            chk("strobe_grant", 32'(grant_id), 32'(mdl_cur));
            chk("strobe_byte", 32'(uart_tx_byte), 32'(e[7:0]));
            chk("strobe_enable", 32'(uart_tx_enable), 32'd1);
            if (cont) chk("lock_gap", 32'(cyc - fall_cyc), 32'd2);
            mdl_sent++;
            if (e[8]) begin
                mdl_ptr = mdl_cur;
                mdl_cur = -1;
            end
        end
        if (busy_mode == 0) begin
            b_on  = cyc + 1 + b_dly;
            b_off = b_on + b_len;
        end
    endtask

    task automatic step();
        logic [N-1:0] rdy;
        logic [N-1:0] vld;
        logic [8:0]   t;
        rdy = req_ready;
        vld = req_valid;
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < N; i++) begin
            if (rdy[i] && vld[i]) t = pend[i].pop_front();
        end
        drive();
        if (watch_idx >= 0 && req_ready[watch_idx]) begin
            watch_hits++;
            watch_at = strobe_cnt;
        end
        if (uart_tx_valid) on_strobe();
    endtask

    task automatic step_to(input int target);
        while (cyc < target) step();
    endtask

    task automatic wait_strobe(input int bound, output int at);
        bit seen;
        seen = 0;
        at = cyc;
        for (int k = 0; k < bound && !seen; k++) begin
            step();
            if (uart_tx_valid) begin
                seen = 1;
                at = cyc;
            end
        end
        checks++;
        assert (seen) else begin
            errors++;
            $error("FAIL strobe_timeout observed=none expected=strobe within %0d cycles", bound);
        end
    endtask

    task automatic drain(input int bound);
        bit done;
        bit empty;
        done = 0;
        for (int k = 0; k < bound && !done; k++) begin
            step();
            empty = 1;
            for (int i = 0; i < N; i++) if (pend[i].size() > 0) empty = 0;
            done = empty && !uart_tx_enable && !uart_tx_busy;
        end
        checks++;
        assert (done) else begin
            errors++;
            $error("FAIL drain_timeout observed=busy expected=idle within %0d cycles", bound);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < N; i++) begin
            pend[i].delete();
            mdl_q[i].delete();
        end
        mdl_ptr  = N - 1;
        mdl_cur  = -1;
        mdl_sent = 0;
        b_on     = 0;
        b_off    = 0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clear_model();
        busy_mode = 0;
        drive();
        step();
        step();
        rst = 1'b1;
    endtask

    int s, s2, base;

    initial begin
        rst = 1'b0; err_clr = 1'b0; req_valid = '0; req_data = '0; req_last = '0;
        uart_tx_busy = 1'b0; busy_prev = 1'b0; fall_cyc = 0; strobe_cnt = 0; seq = 0;
        watch_idx = -1; watch_hits = 0; watch_at = 0;
        busy_mode = 0; b_dly = 2; b_len = 20;
        clear_model();
        drive();
        step();

        // Reset state
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_grant", 32'(grant_id), 32'd0);
        chk("rst_enable", 32'(uart_tx_enable), 32'd0);
        chk("rst_byte", 32'(uart_tx_byte), 32'd0);
        chk("rst_valid", 32'(uart_tx_valid), 32'd0);
        chk("rst_err", 32'(start_err), 32'd0);
        chk("rst_count", 32'(bytes_sent), 32'd0);
        step();
        rst = 1'b1;

        // 1: single byte latency
        load(0, 8'h55, 1'b1);
        drive();
        chk("t1_ready_T", 32'(req_ready), 32'd0);
        step();
        chk("t1_ready_T1", 32'(req_ready), 32'b0001);
        chk("t1_valid_T1", 32'(uart_tx_valid), 32'd0);
        step();
        chk("t1_valid_T2", 32'(uart_tx_valid), 32'd1);
        chk("t1_byte", 32'(uart_tx_byte), 32'h55);
        step();
        chk("t1_count", 32'(bytes_sent), 32'd1);
        chk("t1_valid_once", 32'(uart_tx_valid), 32'd0);
        drain(100);
        chk("t1_release_gap", 32'(cyc - fall_cyc), 32'd1);
        chk("t1_grant_hold", 32'(grant_id), 32'd0);

        // 2: all four requesters, round-robin order 0,1,2,3,0
        do_reset();
        b_dly = 1; b_len = 3; seq = 0;
        load(0, 8'hA0, 1'b1); load(1, 8'hA1, 1'b1); load(2, 8'hA2, 1'b1);
        load(3, 8'hA3, 1'b1); load(0, 8'hA4, 1'b1);
        drive();
        drain(300);
        chk("t2_order", 32'(seq), 32'h01230);
        chk("t2_count", 32'(bytes_sent), 32'd5);

        // 3: locked 3-byte message from requester 2 with requester 1 waiting
        load(1, 8'h11, 1'b1);
        drive();
        drain(100);
        seq = 0; b_dly = 2; b_len = 4;
        base = strobe_cnt;
        watch_idx = 1; watch_hits = 0;
        load(2, 8'hB0, 1'b0); load(2, 8'hB1, 1'b0); load(2, 8'hB2, 1'b1);
        load(1, 8'hB3, 1'b1);
        drive();
        drain(300);
        watch_idx = -1;
        chk("t3_order", 32'(seq), 32'h2221);
        chk("t3_ready1_count", 32'(watch_hits), 32'd1);
        chk("t3_ready1_after_lock", 32'(watch_at), 32'(base + 3));

        // 4: start timeout, clear, and clear colliding with a new timeout
        busy_mode = 1;
        load(3, 8'hC0, 1'b1);
        drive();
        wait_strobe(20, s);
        step_to(s + TO - 1);
        chk("t4_err_early", 32'(start_err), 32'd0);
        step_to(s + TO + 1);
        chk("t4_err_set", 32'(start_err), 32'd1);
        chk("t4_released", 32'(uart_tx_enable), 32'd0);
        chk("t4_grant_hold", 32'(grant_id), 32'd3);
        step();
        chk("t4_err_sticky", 32'(start_err), 32'd1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("t4_err_cleared", 32'(start_err), 32'd0);
        load(0, 8'hC1, 1'b1);
        drive();
        wait_strobe(20, s2);
        step_to(s2 + TO);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("t4_set_beats_clr", 32'(start_err), 32'd1);
        chk("t4_released2", 32'(uart_tx_enable), 32'd0);

        // 5: asynchronous reset during WAIT_DONE of byte 2 of a locked message
        busy_mode = 0; b_dly = 1; b_len = 6;
        load(1, 8'hD0, 1'b0); load(1, 8'hD1, 1'b0); load(1, 8'hD2, 1'b1);
        drive();
        wait_strobe(50, s);
        wait_strobe(50, s);
        step(); step(); step();
        chk("t5_in_wait_done_busy", 32'(uart_tx_busy), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("t5_async_enable", 32'(uart_tx_enable), 32'd0);
        chk("t5_async_grant", 32'(grant_id), 32'd0);
        chk("t5_async_byte", 32'(uart_tx_byte), 32'd0);
        chk("t5_async_count", 32'(bytes_sent), 32'd0);
        chk("t5_async_err", 32'(start_err), 32'd0);
        chk("t5_async_ready", 32'(req_ready), 32'd0);
        clear_model();
        drive();
        step();
        step();
        rst = 1'b1;
        seq = 0;
        load(3, 8'hE3, 1'b1); load(0, 8'hE0, 1'b1); load(2, 8'hE2, 1'b1);
        drive();
        drain(300);
        chk("t5_order", 32'(seq), 32'h023);

        // 6: busy held high blocks arbitration
        busy_mode = 2;
        load(2, 8'hF2, 1'b1);
        drive();
        for (int k = 0; k < 5; k++) begin
            step();
            chk("t6_no_ready", 32'(req_ready), 32'd0);
            chk("t6_no_strobe", 32'(uart_tx_valid), 32'd0);
        end
        busy_mode = 0; b_on = 0; b_off = 0; b_dly = 1; b_len = 2;
        step();
        chk("t6_busy_dropped", 32'(uart_tx_busy), 32'd0);
        chk("t6_ready_D", 32'(req_ready), 32'd0);
        step();
        chk("t6_ready_D1", 32'(req_ready), 32'b0100);
        chk("t6_grant", 32'(grant_id), 32'd2);
        drain(100);

        // Randomized batches of multi-byte messages
        for (int r = 0; r < 10; r++) begin
            b_dly = $urandom_range(0, 3);
            b_len = $urandom_range(1, 5);
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 3) != 0) begin
                    int nm;
                    nm = $urandom_range(1, 2);
                    for (int m = 0; m < nm; m++) begin
                        int len;
                        len = $urandom_range(1, 3);
                        for (int b = 0; b < len; b++) begin
                            load(i, 8'($urandom), (b == len - 1));
                        end
                    end
                end
            end
            drive();
            drain(3000);
        end
        chk("rand_count", 32'(bytes_sent), 32'(mdl_sent % (1 << CW)));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
